// File: rtl/decoder2to4_seq_pkg.sv
// Shared types and constants for the sequenced 2-to-4 decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } dec_state_t;

    localparam int DEC_W    = 32'sd2;
    localparam int ONEHOT_W = 32'sd4;

    // Counter must hold the larger of the two loads; never narrower than one bit.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return ($clog2(m + 32'sd1) < 32'sd1) ? 32'sd1 : $clog2(m + 32'sd1);
    endfunction

endpackage

// File: rtl/decoder2to4.sv
// Combinational 2-to-4 one-hot decoder; en low forces all-zero.
module decoder2to4
    import decoder_pkg::*;
(
    input  logic                en,
    input  logic [DEC_W-1:0]    code_in,
    output logic [ONEHOT_W-1:0] onehot
);

    // Decode the code to a single active line when enabled.
    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            case (code_in)
                2'b00:   onehot = 4'b0001;
                2'b01:   onehot = 4'b0010;
                2'b10:   onehot = 4'b0100;
                2'b11:   onehot = 4'b1000;
                default: onehot = 4'b0000;
            endcase
        end else begin
            onehot = 4'b0000;
        end
    end

endmodule

// File: rtl/decoder2to4_seq.sv
// Sequenced 2-to-4 decoder: accepts a code over valid/ready, holds the
// one-hot line for HOLD cycles, then idles for GAP cycles.
module decoder2to4_seq
    import decoder_pkg::*;
#(
    parameter int HOLD = 32'sd4,
    parameter int GAP  = 32'sd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DEC_W-1:0]    code_in,
    input  logic                code_valid,
    output logic                code_ready,
    output logic [ONEHOT_W-1:0] d_out,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = cnt_width(HOLD, GAP);

    localparam dec_state_t ST_IDLE = decoder_pkg::IDLE;
    localparam dec_state_t ST_HOLD = decoder_pkg::HOLD;
    localparam dec_state_t ST_GAP  = decoder_pkg::GAP;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 32'sd1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP > 32'sd0) ? (GAP - 32'sd1) : 32'sd0);
    localparam bit               GAP_ZERO  = (GAP == 32'sd0);
    localparam bit               HOLD_ONE  = (HOLD == 32'sd1);

    dec_state_t           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 accept_s;
    logic [ONEHOT_W-1:0]  next_d_s;

    // With GAP==0 the last hold cycle doubles as an accept slot for back-to-back codes.
    assign code_ready = enable && ((state_r == ST_IDLE) ||
                                   ((state_r == ST_HOLD) && (cnt_r == CNT_ZERO) && GAP_ZERO));
    assign accept_s   = code_valid && code_ready;

    decoder2to4 u_dec (
        .en      (accept_s),
        .code_in (code_in),
        .onehot  (next_d_s)
    );

    // FSM, hold/gap counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            d_out   <= 4'b0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_HOLD;
                        cnt_r   <= HOLD_LOAD;
                        d_out   <= next_d_s;
                        busy    <= 1'b1;
                        done    <= HOLD_ONE;
                    end else begin
                        d_out   <= 4'b0000;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r != CNT_ZERO) begin
                        // done is registered, so raise it one edge ahead of the final hold cycle.
                        cnt_r   <= cnt_r - CNT_ONE;
                        done    <= (cnt_r == CNT_ONE);
                    end else if (!GAP_ZERO) begin
                        state_r <= ST_GAP;
                        cnt_r   <= GAP_LOAD;
                        d_out   <= 4'b0000;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else if (accept_s) begin
                        cnt_r   <= HOLD_LOAD;
                        d_out   <= next_d_s;
                        busy    <= 1'b1;
                        done    <= HOLD_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                        d_out   <= 4'b0000;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                ST_GAP: begin
                    done <= 1'b0;
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    d_out   <= 4'b0000;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder2to4_seq.sv
// Self-checking bench: directed scenarios plus random traffic against a
// timeline model (each accepted code expands into its per-cycle outputs).
module tb_decoder2to4_seq;

    logic       clk = 1'b0;
    logic       rst, enable, code_valid;
    logic [1:0] code_in;
    bit         sel;

    logic       valid_a, ready_a, busy_a, done_a;
    logic       valid_b, ready_b, busy_b, done_b;
    logic [3:0] d_a, d_b;

    assign valid_a = code_valid && !sel;
    assign valid_b = code_valid && sel;

    always #5 clk = ~clk;

    decoder2to4_seq #(.HOLD(4), .GAP(2)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .code_in(code_in),
        .code_valid(valid_a), .code_ready(ready_a), .d_out(d_a),
        .busy(busy_a), .done(done_a)
    );

    decoder2to4_seq #(.HOLD(2), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .code_in(code_in),
        .code_valid(valid_b), .code_ready(ready_b), .d_out(d_b),
        .busy(busy_b), .done(done_b)
    );

    typedef struct packed {
        logic [3:0] d;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   hold_m, gap_m;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_seen = 0;
    bit   last_acc = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    function automatic bit model_ready();
        return enable && ((q.size() == 0) || ((gap_m == 0) && (q.size() == 1)));
    endfunction

    // One clock: check ready, advance the model at the edge, check outputs after it.
    task automatic tick();
        bit         rdy;
        logic [1:0] c;
        exp_t       e;
        logic       r_obs, b_obs, dn_obs;
        logic [3:0] d_obs;
        #1;
        rdy   = model_ready();
        c     = code_in;
        r_obs = sel ? ready_b : ready_a;
        chk("code_ready", {7'd0, r_obs}, {7'd0, rdy});
        last_acc = !rst && code_valid && rdy;
        @(posedge clk);
        cyc++;
        if (q.size() > 0) void'(q.pop_front());
        if (rst || !enable) begin
            q.delete();
        end else if (last_acc) begin
            for (int i = 0; i < hold_m; i++)
                q.push_back('{d: 4'b0001 << c, busy: 1'b1, done: (i == hold_m - 1)});
            for (int i = 0; i < gap_m; i++)
                q.push_back('{d: 4'b0000, busy: 1'b1, done: 1'b0});
        end
        @(negedge clk);
        e      = (q.size() > 0) ? q[0] : '0;
        d_obs  = sel ? d_b    : d_a;
        b_obs  = sel ? busy_b : busy_a;
        dn_obs = sel ? done_b : done_a;
        chk("d_out", {4'd0, d_obs}, {4'd0, e.d});
        chk("busy",  {7'd0, b_obs}, {7'd0, e.busy});
        chk("done",  {7'd0, dn_obs}, {7'd0, e.done});
        if (dn_obs === 1'b1) done_seen++;
    endtask

    task automatic send(input logic [1:0] c, input bit drop);
        int n;
        n          = 0;
        code_in    = c;
        code_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 30);
        chk("accept", {7'd0, last_acc}, 8'd1);
        if (drop) code_valid = 1'b0;
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            enable = ($urandom_range(15) != 0);
            rst    = ($urandom_range(63) == 0);
            if (!code_valid || last_acc) begin
                code_valid = 1'($urandom_range(1));
                code_in    = 2'($urandom_range(3));
            end
            tick();
        end
    endtask

    initial begin
        int acc_cyc[4];

        sel = 1'b0; hold_m = 4; gap_m = 2;
        rst = 1'b1; enable = 1'b1; code_valid = 1'b1; code_in = 2'b10;
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        code_valid = 1'b0;

        // Single code, then drain through the gap into idle.
        send(2'b10, 1'b1);
        repeat (7) tick();

        // All four codes streamed with valid held high.
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            send(2'(i), 1'b0);
            acc_cyc[i] = cyc;
        end
        code_valid = 1'b0;
        repeat (8) tick();
        chk("done_count", 8'(done_seen), 8'd4);
        for (int i = 1; i < 4; i++) chk("period", 8'(acc_cyc[i] - acc_cyc[i-1]), 8'd7);

        // Abort on the second hold cycle.
        done_seen = 0;
        send(2'b01, 1'b1);
        tick();
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (6) tick();
        chk("abort_done", 8'(done_seen), 8'd0);

        // Reset during the first gap cycle.
        send(2'b11, 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        rand_run(400);

        // Switch to the HOLD=2, GAP=0 instance.
        code_valid = 1'b0; enable = 1'b1; rst = 1'b1;
        tick();
        sel = 1'b1; hold_m = 2; gap_m = 0;
        tick();
        rst = 1'b0;
        tick();

        done_seen = 0;
        send(2'b11, 1'b0);
        send(2'b00, 1'b1);
        tick();
        chk("b2b_done", 8'(done_seen), 8'd2);
        repeat (3) tick();

        rand_run(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder2to4_seq.md
# decoder2to4_seq

Sequenced 2-to-4 decoder: the receive-side counterpart of the team's enabled 4-to-2 encoder. It accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot line on `d_out` for a programmable number of cycles. It then inserts an optional idle gap before accepting the next code. It sits downstream of encoded channel-select logic and drives one-hot strobes or enables into four consumers.

## Interface
Parameters:
- `HOLD`, default 4: cycles each one-hot output is held. Must be ≥1.
- `GAP`, default 1: all-zero cycles after each hold. Must be ≥0.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `enable`  input  1  block enable. Low aborts any activity and forces outputs to zero.
- `code_in`  input  2  code to decode: 00→0001, 01→0010, 10→0100, 11→1000.
- `code_valid`  input  1  `code_in` is valid.
- `code_ready`  output  1  block can accept a code this cycle. Combinational from state and `enable`.
- `d_out`  output  4  registered one-hot output. All-zero when not in HOLD.
- `busy`  output  1  registered. High in HOLD and GAP.
- `done`  output  1  registered. One-cycle pulse on the last HOLD cycle of each completed code.

## Operation
- FSM states are IDLE, HOLD and GAP. The counter `cnt` has width `$clog2(max(HOLD,GAP)+1)`, minimum 1 bit.
- Handshake: a code is accepted on an edge where `code_valid && code_ready`. `code_ready` is `enable && (state==IDLE || (state==HOLD && cnt==0 && GAP==0))`.
- Producer rule: `code_in` must be stable while `code_valid` is high and `code_ready` is low. The block never drops an accepted code.
- IDLE behaviour:
  - `d_out`=0 and `busy`=0.
  - On accept: go to HOLD, load `d_out` with the decode of `code_in`, load `cnt`=HOLD-1.
- HOLD behaviour:
  - `d_out` is held and `cnt` decrements each cycle.
  - When `cnt`==0, this cycle is the last hold cycle and `done`=1.
  - At the next edge:
    - If GAP>0: go to GAP with `cnt`=GAP-1 and `d_out`=0.
    - If GAP==0 and a new code is accepted: stay in HOLD, load the new `d_out` and `cnt`=HOLD-1. This gives back-to-back codes with no zero cycle between them.
    - Otherwise: go to IDLE with `d_out`=0.
- GAP behaviour: `d_out`=0 and `busy`=1. `cnt` decrements; at `cnt`==0 go to IDLE.
- `enable` low, any state: at the next edge go to IDLE, set `d_out`=0, `busy`=0, `done`=0, `cnt`=0. An aborted code produces no `done`. `code_ready`=0 while `enable` is low.
- `rst` high: at the next edge the state becomes IDLE and `d_out`=0000, `busy`=0, `done`=0, `cnt`=0. Reset has priority over `enable` and the handshake. A reset during HOLD or GAP discards the code silently.

## Timing
- Accept at edge k: `d_out` is one-hot from after edge k through edge k+HOLD, i.e. exactly HOLD cycles.
- `done` is high in the cycle before edge k+HOLD, aligned with the final hold cycle.
- Zero cycles after the hold:
  - GAP>0: `d_out` is zero for GAP cycles in GAP, plus at least one IDLE cycle before the next accept.
  - GAP==0: no zero cycle when the next code is accepted on the last hold cycle.
- Throughput: one code per HOLD+GAP+1 cycles when GAP>0. One code per HOLD cycles when GAP==0.
- `code_ready` is combinational. `d_out`, `busy` and `done` are flop outputs with no combinational path from the inputs.

## Structure
- Shared package `decoder_pkg`: state enum `dec_state_t` {IDLE, HOLD, GAP}, plus constant `DEC_W`=2 and `ONEHOT_W`=4.
- Sub-module `decoder2to4`: purely combinational, `code_in[1:0]` → one-hot `[3:0]`, with an `en` input that forces zero. It is instantiated once to produce the next value of `d_out`.
- The top level holds the FSM, the counter and the output registers.

## Test plan
Unless stated otherwise, HOLD=4, GAP=2, `enable`=1.
- Reset: hold `rst` for 2 cycles while `code_valid`=1 → `d_out`=0000, `busy`=0, `done`=0, and no accept while `rst` is high.
- Single code: `code_in`=10 accepted at edge k → `d_out`=0100 for 4 cycles with `done` on the 4th, then 0000 with `busy`=1 for 2 cycles. `code_ready` rises in IDLE on the cycle after the gap.
- All codes: 00, 01, 10, 11 streamed with `code_valid` held high → `d_out` sequence 0001, 0010, 0100, 1000, each held 4 cycles. Exactly four `done` pulses, no lost code, one code per 7 cycles.
- Back-to-back, HOLD=2, GAP=0: codes 11 then 00 → `d_out` reads 1000, 1000, 0001, 0001 with no zero cycle between them, and `done` on cycles 2 and 4.
- Abort: `enable` dropped on the 2nd hold cycle of code 01 → `d_out`=0000 and `busy`=0 after the next edge, no `done`, and `code_ready` stays 0 until `enable` returns.
- Reset mid-GAP: `rst` asserted in the 1st GAP cycle → IDLE at the next edge. `code_ready`=1 in the first cycle after `rst` deasserts.
